gate_response_checker: RTL and testbench

//  Consumer side of the gate stimulus/response stream: samples (a, b, y) vectors

---
 rtl/gate_chk_pkg.sv | 38 +++
 rtl/gate_response_checker.sv | 114 +++++++++++
 tb/tb_gate_response_checker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: gate selector codes,
// FSM state encoding and the golden 2-input gate function.
package gate_chk_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_XOR  = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic gate_sel_legal(input logic [2:0] sel);
    return sel <= GATE_XNOR;
  endfunction

  // Reserved selectors never reach evaluation; they return 0 to keep the function total.
  function automatic logic gate_eval(input logic [2:0] sel, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (sel)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_XOR:  r = a ^ b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XNOR: r = ~(a ^ b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_response_checker.sv
// Compares sampled (a, b, y) vectors against the golden gate function, counts
// vectors and mismatches, captures the first failure; 1-cycle latency, no backpressure.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_VEC = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cfg_err,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e     state;
  state_e     state_nxt;
  logic [2:0] sel_q;

  logic start_ok;
  logic start_bad;
  logic accept;
  logic exp_y;
  logic mismatch;
  logic last_vec;

  // start is only meaningful outside a run; inside RUN it is dropped silently.
  assign start_ok  = start && (state != ST_RUN) && gate_sel_legal(gate_sel);
  assign start_bad = start && (state != ST_RUN) && !gate_sel_legal(gate_sel);
  assign accept    = (state == ST_RUN) && vld;
  assign exp_y     = gate_eval(sel_q, a, b);
  assign mismatch  = accept && (y != exp_y);
  assign last_vec  = accept && (vec_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_RUN;
      ST_RUN:  if (last_vec) state_nxt = ST_DONE;
      ST_DONE: if (start_ok) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (err_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= GATE_AND;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      if (start_ok) sel_q <= gate_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (start_ok) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Only the first mismatch of a run is captured; later ones just bump err_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (start_ok) begin
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (mismatch && !fail_seen) begin
      fail_seen      <= 1'b1;
      first_fail_idx <= vec_cnt;
      first_fail_vec <= {a, b, y};
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized and directed bench for gate_response_checker against a truth-table reference model.
module tb_gate_response_checker;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    gate_sel;
  logic          vld;
  logic          a;
  logic          b;
  logic          y;
  logic          busy;
  logic          done;
  logic          pass;
  logic          cfg_err;
  logic [CW-1:0] vec_cnt;
  logic [CW-1:0] err_cnt;
  logic          fail_seen;
  logic [CW-1:0] first_fail_idx;
  logic [2:0]    first_fail_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference results of the most recent run.
  int         m_err;
  int         m_idx;
  logic [2:0] m_vec;
  logic       m_seen;

  gate_response_checker #(.N_VEC(N), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .gate_sel       (gate_sel),
    .vld            (vld),
    .a              (a),
    .b              (b),
    .y              (y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .cfg_err        (cfg_err),
    .vec_cnt        (vec_cnt),
    .err_cnt        (err_cnt),
    .fail_seen      (fail_seen),
    .first_fail_idx (first_fail_idx),
    .first_fail_vec (first_fail_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Golden gate from the number of high inputs.
  function automatic logic ref_gate(input logic [2:0] s, input logic ai, input logic bi);
    int ones;
    ones = int'(ai) + int'(bi);
    case (s)
      3'd0:    return ones == 2;
      3'd1:    return ones > 0;
      3'd2:    return ones == 1;
      3'd3:    return ones != 2;
      3'd4:    return ones == 0;
      3'd5:    return ones != 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    chk({tag, "_vec_cnt"}, 32'(vec_cnt), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_fail_seen"}, 32'(fail_seen), 0);
    chk({tag, "_ff_idx"}, 32'(first_fail_idx), 0);
    chk({tag, "_ff_vec"}, 32'(first_fail_vec), 0);
  endtask

  // Called right after a negedge; returns at the following negedge with start low.
  task automatic do_start(input logic [2:0] s);
    start    = 1'b1;
    gate_sel = s;
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 3'($urandom_range(0, 7));
  endtask

  task automatic run_vecs(input logic [2:0] s, input logic [2:0] v[N], input bit gaps);
    do_start(s);
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_vec_cnt", 32'(vec_cnt), 0);
    chk("start_err_cnt", 32'(err_cnt), 0);
    chk("start_fail_seen", 32'(fail_seen), 0);
    m_err  = 0;
    m_idx  = 0;
    m_vec  = 3'b000;
    m_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          vld      = 1'b0;
          start    = ($urandom_range(0, 2) == 0);
          gate_sel = 3'($urandom_range(0, 7));
          @(negedge clk);
          start = 1'b0;
          chk("gap_vec_cnt", 32'(vec_cnt), 32'(i));
          chk("gap_busy", 32'(busy), 1);
          chk("gap_cfg_err", 32'(cfg_err), 0);
        end
      end
      {a, b, y} = v[i];
      vld       = 1'b1;
      gate_sel  = 3'($urandom_range(0, 7));
      @(negedge clk);
      vld = 1'b0;
      if (v[i][0] != ref_gate(s, v[i][2], v[i][1])) begin
        if (!m_seen) begin
          m_seen = 1'b1;
          m_idx  = i;
          m_vec  = v[i];
        end
        if (m_err < (1 << CW) - 1) m_err++;
      end
      chk("vec_cnt", 32'(vec_cnt), 32'(i + 1));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("fail_seen", 32'(fail_seen), 32'(m_seen));
    end
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 1);
    chk("end_pass", 32'(pass), 32'(m_err == 0));
    chk("end_ff_idx", 32'(first_fail_idx), 32'(m_idx));
    chk("end_ff_vec", 32'(first_fail_vec), 32'(m_vec));
    // Vectors after completion must not disturb the verdict.
    repeat (2) begin
      {a, b, y} = 3'($urandom_range(0, 7));
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    chk("done_vld_vec_cnt", 32'(vec_cnt), 32'(N));
    chk("done_vld_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("done_vld_done", 32'(done), 1);
  endtask

  initial begin
    logic [2:0] v[N];
    logic [2:0] s;
    logic       ai;
    logic       bi;

    rst_n    = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    vld      = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    y        = 1'b0;

    // Reset asserted mid-clock must clear outputs without a clock edge.
    #3 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // vld in IDLE is ignored.
    vld = 1'b1; {a, b, y} = 3'b111;
    @(negedge clk);
    vld = 1'b0;
    chk("idle_vld_vec_cnt", 32'(vec_cnt), 0);
    chk("idle_vld_busy", 32'(busy), 0);

    // Reserved selector rejected with a one-cycle cfg_err.
    do_start(3'd6);
    chk("rsv_cfg_err", 32'(cfg_err), 1);
    chk("rsv_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rsv_cfg_err_clear", 32'(cfg_err), 0);

    // start + vld together in IDLE: start wins, vector not counted.
    vld = 1'b1; {a, b, y} = 3'b101;
    do_start(3'd2);
    vld = 1'b0;
    chk("sv_busy", 32'(busy), 1);
    chk("sv_vec_cnt", 32'(vec_cnt), 0);
    v = '{3'b000, 3'b011, 3'b101, 3'b110};
    run_vecs(3'd2, v, 1'b0);
    chk("xor_pass", 32'(pass), 1);

    // OR, all correct.
    v = '{3'b000, 3'b011, 3'b101, 3'b111};
    run_vecs(3'd1, v, 1'b0);
    chk("or_vec_cnt", 32'(vec_cnt), 4);
    chk("or_err_cnt", 32'(err_cnt), 0);
    chk("or_pass", 32'(pass), 1);

    // OR with a wrong final response.
    v = '{3'b000, 3'b011, 3'b101, 3'b110};
    run_vecs(3'd1, v, 1'b0);
    chk("or_bad_err_cnt", 32'(err_cnt), 1);
    chk("or_bad_pass", 32'(pass), 0);
    chk("or_bad_fail_seen", 32'(fail_seen), 1);
    chk("or_bad_ff_idx", 32'(first_fail_idx), 3);
    chk("or_bad_ff_vec", 32'(first_fail_vec), 32'(3'b110));

    // AND checked against OR responses.
    v = '{3'b000, 3'b011, 3'b101, 3'b111};
    run_vecs(3'd0, v, 1'b0);
    chk("and_err_cnt", 32'(err_cnt), 2);
    chk("and_ff_idx", 32'(first_fail_idx), 1);
    chk("and_ff_vec", 32'(first_fail_vec), 32'(3'b011));

    // Reserved restart from DONE keeps the previous verdict.
    do_start(3'd7);
    chk("rsv_done_cfg_err", 32'(cfg_err), 1);
    chk("rsv_done_done", 32'(done), 1);
    chk("rsv_done_err_cnt", 32'(err_cnt), 2);
    @(negedge clk);
    chk("rsv_done_cfg_clear", 32'(cfg_err), 0);

    // Reset mid-run discards the partial run.
    do_start(3'd5);
    repeat (2) begin
      {a, b, y} = 3'b000;
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    chk("mid_vec_cnt", 32'(vec_cnt), 2);
    chk("mid_err_cnt", 32'(err_cnt), 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{3'b001, 3'b010, 3'b100, 3'b111};
    run_vecs(3'd5, v, 1'b0);
    chk("xnor_pass", 32'(pass), 1);

    // Randomized runs with idle gaps and ignored start pulses.
    for (int r = 0; r < 30; r++) begin
      s = 3'($urandom_range(0, 5));
      for (int i = 0; i < N; i++) begin
        ai   = 1'($urandom_range(0, 1));
        bi   = 1'($urandom_range(0, 1));
        v[i] = {ai, bi, ref_gate(s, ai, bi) ^ ($urandom_range(0, 3) == 0)};
      end
      run_vecs(s, v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
